chunked_adder_seq: RTL and testbench

- Multi-cycle wide adder. Accepts two W-bit operands plus a carry-in over a valid/ready handshake.
- Adds them CHUNK_W bits per cycle, least significant chunk first, through a single CHUNK_W-bit ripple chunk adder. A registered carry links consecutive chunks.
- Presents the W-bit sum and carry-out on a valid/ready output port.
- Sits upstream of wide-datapath consumers where a full-width ripple chain would miss timing; trades latency for logic depth.

---
 rtl/adder_pkg.sv | 19 +
 rtl/chunked_adder_seq_chunk_adder.sv | 23 ++
 rtl/chunked_adder_seq.sv | 168 ++++++++++++++++
 tb/tb_chunked_adder_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_w(input int chunk_w, input int num_chunks);
    return chunk_w * num_chunks;
  endfunction

  // Chunk index needs at least one bit even when there is a single chunk.
  function automatic int idx_width(input int num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

endpackage

// File: rtl/chunked_adder_seq_chunk_adder.sv
// Combinational CHUNK_W-bit ripple adder with carry-in and carry-out.
module chunk_adder #(
  parameter int CHUNK_W = 4
) (
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               cin_i,
  output logic [CHUNK_W-1:0] sum_o,
  output logic               cout_o
);

  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/chunked_adder_seq.sv
// Multi-cycle wide adder: one CHUNK_W-bit chunk per cycle, LSB chunk first.
// Define CHUNKED_ADDER_OVF_EN to add the registered out_ovf port.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding chunk idx_q each cycle
// DONE  | result held on out_sum/out_cout until out_ready
module chunked_adder_seq
  import adder_pkg::*;
#(
  parameter  int CHUNK_W    = 4,
  parameter  int NUM_CHUNKS = 4,
  localparam int W          = calc_w(CHUNK_W, NUM_CHUNKS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
`ifdef CHUNKED_ADDER_OVF_EN
  ,
  output logic         out_ovf
`endif
);

  localparam int IW = idx_width(NUM_CHUNKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHUNKS - 1);

  state_t state_q, state_d;

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
`ifdef CHUNKED_ADDER_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic [CHUNK_W-1:0] a_chunk, b_chunk, chunk_sum;
  logic               chunk_cout;
  logic               last_chunk;

  assign last_chunk = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Chunk operand mux
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (idx_q == IW'(i)) begin
        a_chunk = a_q[i*CHUNK_W +: CHUNK_W];
        b_chunk = b_q[i*CHUNK_W +: CHUNK_W];
      end
    end
  end

  chunk_adder #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk_adder (
    .a_i    (a_chunk),
    .b_i    (b_chunk),
    .cin_i  (carry_q),
    .sum_o  (chunk_sum),
    .cout_o (chunk_cout)
  );

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        for (int i = 0; i < NUM_CHUNKS; i++) begin
          if (idx_q == IW'(i)) sum_d[i*CHUNK_W +: CHUNK_W] = chunk_sum;
        end
        carry_d = chunk_cout;
        if (last_chunk) begin
          idx_d  = '0;
          cout_d = chunk_cout;
`ifdef CHUNKED_ADDER_OVF_EN
          // Same-sign operands whose sum sign differs overflow.
          ovf_d  = (a_q[W-1] == b_q[W-1]) && (chunk_sum[CHUNK_W-1] != a_q[W-1]);
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
  assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Scoreboard bench for chunked_adder_seq with hand-computed directed vectors.
module tb_chunked_adder_seq;

  localparam int CW = 4;
  localparam int NC = 4;
  localparam int W  = CW * NC;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef CHUNKED_ADDER_OVF_EN
  logic         out_ovf;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  chunked_adder_seq #(.CHUNK_W(CW), .NUM_CHUNKS(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every cycle the result is presented, pops on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("out_sum", 32'(out_sum), 32'(sb[0].sum));
        chk("out_cout", 32'(out_cout), 32'(sb[0].cout));
`ifdef CHUNKED_ADDER_OVF_EN
        chk("out_ovf", 32'(out_ovf), 32'(sb[0].ovf));
`endif
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands and returns #1 after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int budget;
    budget = 0;
    while (!in_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!in_ready) chk("send_timeout", 32'd1, 32'd0);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    int budget;
    budget = 0;
    while (!out_valid && budget < 50) begin
      tick();
      budget++;
    end
    if (!out_valid) chk(name, 32'd0, 32'd1);
  endtask

  task automatic wait_accept(output int t);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    t = cyc;
  endtask

  initial begin
    int t1, t2;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_sum", 32'(out_sum), 32'd0);
    chk("reset_out_cout", 32'(out_cout), 32'd0);

    // Carry across all chunk boundaries, latency check.
    push(16'h0000, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0);
    for (int k = 1; k <= NC; k++) begin
      if (k < NC) chk("latency_early", 32'(out_valid), 32'd0);
      tick();
    end
    chk("latency_valid", 32'(out_valid), 32'd1);
    tick();

    // in_ready low during operation, high after handshake.
    push(16'h5556, 1'b0, 1'b0);
    send(16'h1234, 16'h4321, 1'b1);
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    wait_valid("t2_timeout");
    chk("done_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);

    // Backpressure with a pending new request.
    out_ready = 1'b0;
    push(16'h0100, 1'b0, 1'b0);
    send(16'h00F0, 16'h0010, 1'b0);
    wait_valid("t3_timeout");
    in_a     = 16'hAAAA;
    in_b     = 16'h5555;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back issue.
    push(16'h0011, 1'b0, 1'b0);
    push(16'hFFFF, 1'b0, 1'b0);
    in_a     = 16'h0010;
    in_b     = 16'h0001;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    wait_accept(t1);
    tick();
    in_a = 16'hF0F0;
    in_b = 16'h0F0F;
    wait_accept(t2);
    tick();
    in_valid = 1'b0;
    chk("b2b_spacing", 32'(t2 - t1), 32'd6);
    wait_valid("t4_timeout");
    tick();

    // Reset mid-RUN discards the partial result.
    send(16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_sum", 32'(out_sum), 32'd0);
    chk("midrst_out_cout", 32'(out_cout), 32'd0);
    push(16'h0003, 1'b0, 1'b0);
    send(16'h0001, 16'h0002, 1'b0);
    wait_valid("t5_timeout");
    tick();

`ifdef CHUNKED_ADDER_OVF_EN
    push(16'h8000, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0);
    push(16'h0000, 1'b1, 1'b1);
    send(16'h8000, 16'h8000, 1'b0);
    push(16'h0000, 1'b1, 1'b0);
    send(16'h0001, 16'hFFFF, 1'b0);
    wait_valid("ovf_timeout");
    tick();
`endif

    begin
      int budget;
      budget = 0;
      while (sb.size() != 0 && budget < 100) begin
        tick();
        budget++;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
